// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shifting 3x3 register, emitting only
// fully interior windows. Optional frame resync input enabled by SOBEL_WINDOW_FRAME_SYNC_EN.
module sobel_window_gen #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_in_valid,
`ifdef SOBEL_WINDOW_FRAME_SYNC_EN
  input  logic        frame_start,
`endif
  output logic [71:0] window_out,
  output logic        window_out_valid,
  output logic        frame_done
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

  typedef enum logic {StFill, StActive} state_e;

  state_e          state_q, state_d;
  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic [8:0][7:0] win_q, win_d;
  logic [71:0]     out_q, out_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  logic [7:0]      lb0_q [IMG_WIDTH];
  logic [7:0]      lb1_q [IMG_WIDTH];

  // Effective position of the incoming pixel, after any resync override.
  logic            sync;
  logic [ColW-1:0] pos_col;
  logic [RowW-1:0] pos_row;
  state_e          pos_state;
  logic            col_last, row_last, emit;
  logic [2:0][7:0] new_col;

  always_comb begin
    sync = 1'b0;
`ifdef SOBEL_WINDOW_FRAME_SYNC_EN
    sync = frame_start & pixel_in_valid;
`endif
    pos_col   = sync ? '0 : col_q;
    pos_row   = sync ? '0 : row_q;
    pos_state = sync ? StFill : state_q;
    col_last  = (pos_col == ColLast);
    row_last  = (pos_row == RowLast);
    new_col   = {pixel_in, lb0_q[pos_col], lb1_q[pos_col]};
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    out_d   = out_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    emit    = 1'b0;

    if (pixel_in_valid) begin
      col_d = col_last ? '0 : pos_col + ColW'(1);
      if (col_last) begin
        row_d = row_last ? '0 : pos_row + RowW'(1);
      end else begin
        row_d = pos_row;
      end

      state_d = pos_state;
      unique case (pos_state)
        StFill:   if (col_last && pos_row == RowW'(1)) state_d = StActive;
        StActive: if (col_last && row_last) state_d = StFill;
        default:  state_d = StFill;
      endcase

      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r + 1];
        win_d[3*r + 1] = win_q[3*r + 2];
        win_d[3*r + 2] = new_col[r];
      end

      // col >= 2 keeps all three window columns inside the current row span.
      emit    = (pos_state == StActive) && (pos_col >= ColW'(2));
      valid_d = emit;
      done_d  = emit && col_last && row_last;
      if (emit) out_d = win_d;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= StFill;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Line buffers are plain storage; old contents are never observed before being rewritten.
  always_ff @(posedge clk) begin
    if (pixel_in_valid) begin
      lb1_q[pos_col] <= lb0_q[pos_col];
      lb0_q[pos_col] <= pixel_in;
    end
  end

  assign window_out       = out_q;
  assign window_out_valid = valid_q;
  assign frame_done       = done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen: a frame-image model predicts each interior window.
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic        pixel_in_valid = 1'b0;
  logic        fs_drv = 1'b0;
  logic [71:0] window_out;
  logic        window_out_valid;
  logic        frame_done;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk              (clk),
    .rstN             (rstN),
    .pixel_in         (pixel_in),
    .pixel_in_valid   (pixel_in_valid),
`ifdef SOBEL_WINDOW_FRAME_SYNC_EN
    .frame_start      (fs_drv),
`endif
    .window_out       (window_out),
    .window_out_valid (window_out_valid),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] win;
    logic        done;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc_cnt = 0;
  logic [7:0]  img [H][W];
  int          n = 0;          // raster index of next pixel within the frame
  logic [71:0] last_win = '0;
  int          seg_cnt = 0;
  int          seg_done = 0;
  logic [71:0] seg_first = '0;
  logic [71:0] seg_last = '0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [71:0] pack9(input int b0, b1, b2, b3, b4, b5, b6, b7, b8);
    return {8'(b8), 8'(b7), 8'(b6), 8'(b5), 8'(b4), 8'(b3), 8'(b2), 8'(b1), 8'(b0)};
  endfunction

  // Monitor: every output pulse must match the head of the scoreboard, on the predicted cycle.
  always @(negedge clk) begin
    if (rstN) begin
      if (window_out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window", window_out, '0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("window", window_out, e.win);
          chk("frame_done", 72'(frame_done), 72'(e.done));
          chk("latency", 72'(cyc_cnt), 72'(e.cyc));
        end
        if (seg_cnt == 0) seg_first = window_out;
        seg_last = window_out;
        seg_cnt++;
        if (frame_done) seg_done++;
        last_win = window_out;
      end else begin
        chk("done_without_valid", 72'(frame_done), 72'd0);
        chk("hold_in_gap", window_out, last_win);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
          chk("missing_window", 72'(window_out_valid), 72'd1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] p, input bit fs);
    int r, c;
    exp_t e;
    @(posedge clk); #1;
    pixel_in = p;
    pixel_in_valid = 1'b1;
    fs_drv = fs;
`ifdef SOBEL_WINDOW_FRAME_SYNC_EN
    if (fs) n = 0;
`endif
    r = n / W;
    c = n % W;
    img[r][c] = p;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 9; i++) e.win[i*8 +: 8] = img[r - 2 + i / 3][c - 2 + i % 3];
      e.done = (n == W * H - 1);
      e.cyc  = cyc_cnt + 1;
      exp_q.push_back(e);
    end
    n = (n + 1) % (W * H);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      pixel_in_valid = 1'b0;
      fs_drv = 1'b0;
      pixel_in = 8'($urandom);
    end
  endtask

  // mode 0: pixel = index, mode 1: 100 + index, mode 2: random
  task automatic send_frame(input int mode, input bit gaps);
    for (int i = 0; i < W * H; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      case (mode)
        0:       send(8'(i), 1'b0);
        1:       send(8'(100 + i), 1'b0);
        default: send(8'($urandom), 1'b0);
      endcase
    end
    idle(3);
  endtask

  task automatic seg_reset();
    seg_cnt = 0;
    seg_done = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstN = 1'b0;
    pixel_in_valid = 1'b0;
    #1;
    chk("reset_valid", 72'(window_out_valid), 72'd0);
    chk("reset_window", window_out, '0);
    chk("reset_done", 72'(frame_done), 72'd0);
    exp_q.delete();
    n = 0;
    last_win = '0;
    idle(2);
    rstN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rstN = 1'b0;
    #1;
    chk("por_window", window_out, '0);
    chk("por_valid", 72'(window_out_valid), 72'd0);
    idle(2);
    rstN = 1'b1;
    idle(1);

    // Continuous frame with pixel = raster index
    seg_reset();
    send_frame(0, 1'b0);
    chk("t1_count", 72'(seg_cnt), 72'd24);
    chk("t1_done_count", 72'(seg_done), 72'd1);
    chk("t1_first", seg_first, pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    chk("t1_last", seg_last, pack9(29, 30, 31, 37, 38, 39, 45, 46, 47));

    // Same frame with random idle gaps
    seg_reset();
    send_frame(0, 1'b1);
    chk("t2_count", 72'(seg_cnt), 72'd24);
    chk("t2_first", seg_first, pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));
    chk("t2_last", seg_last, pack9(29, 30, 31, 37, 38, 39, 45, 46, 47));

    // Two frames back to back
    seg_reset();
    for (int i = 0; i < W * H; i++) send(8'(i), 1'b0);
    for (int i = 0; i < W * H; i++) send(8'(100 + i), 1'b0);
    idle(3);
    chk("t3_count", 72'(seg_cnt), 72'd48);
    chk("t3_done_count", 72'(seg_done), 72'd2);
    chk("t3_last", seg_last, pack9(129, 130, 131, 137, 138, 139, 145, 146, 147));

    // Reset after pixel 30, then a clean frame
    for (int i = 0; i <= 30; i++) send(8'(i), 1'b0);
    idle(2);
    do_reset();
    seg_reset();
    send_frame(0, 1'b0);
    chk("t4_count", 72'(seg_cnt), 72'd24);
    chk("t4_first", seg_first, pack9(0, 1, 2, 8, 9, 10, 16, 17, 18));

    // Random pixel frames with gaps
    seg_reset();
    send_frame(2, 1'b1);
    send_frame(2, 1'b0);
    chk("t5_count", 72'(seg_cnt), 72'd48);

`ifdef SOBEL_WINDOW_FRAME_SYNC_EN
    // Resync on pixel 20 of a frame
    for (int i = 0; i < 20; i++) send(8'(i), 1'b0);
    idle(2);
    seg_reset();
    send(8'd200, 1'b1);
    for (int i = 1; i < W * H; i++) send(8'(200 + i), 1'b0);
    idle(3);
    chk("t6_count", 72'(seg_cnt), 72'd24);
    chk("t6_done_count", 72'(seg_done), 72'd1);
    chk("t6_first", seg_first, pack9(200, 201, 202, 208, 209, 210, 216, 217, 218));
`endif

    idle(4);
    chk("drain", 72'(exp_q.size()), 72'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator feeding the Sobel gradient stage. Accepts one 8-bit grayscale pixel per valid cycle in raster order, buffers the two previous image rows in internal line buffers, and emits the full 3x3 neighbourhood as a packed 72-bit word with a valid strobe. Only fully interior windows are emitted; border pixels never appear at the window centre. Output connects directly to the gradient stage's `gradient_data_in` / `gradient_data_in_valid`.

## Interface
- `IMG_WIDTH`, 640, pixels per row; must be >= 3
- `IMG_HEIGHT`, 480, rows per frame; must be >= 3

- `clk`  in  1  clock, rising edge
- `rstN`  in  1  asynchronous active-low reset
- `pixel_in`  in  8  unsigned input pixel
- `pixel_in_valid`  in  1  pixel_in is accepted this cycle
- `frame_start`  in  1  resync strobe; present only with `SOBEL_WINDOW_FRAME_SYNC_EN`
- `window_out`  out  72  packed window; byte i = `window_out[i*8+:8]`, i = 3*r + c, r = 0 oldest row, c = 0 leftmost column (byte 0 top-left, byte 4 centre, byte 8 bottom-right = newest pixel)
- `window_out_valid`  out  1  window_out holds a new interior window
- `frame_done`  out  1  one-cycle pulse coincident with the last window of a frame

## Operation
- No backpressure: every cycle with `pixel_in_valid` = 1 consumes a pixel. Idle cycles (valid = 0) change no state; `window_out` holds its value.
- Counters: `col` 0..IMG_WIDTH-1, `row` 0..IMG_HEIGHT-1, widths $clog2 of the bound. Per accepted pixel: col increments; at IMG_WIDTH-1 it wraps to 0 and row increments; at (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0 (next frame starts immediately).
- Line buffers LB0 (row-1) and LB1 (row-2), IMG_WIDTH x 8 each, addressed by `col`, read-before-write in the same cycle: LB1[col] <= LB0[col], LB0[col] <= pixel_in. Buffer contents are not reset.
- Window register: 3 columns x 3 rows. On accept, shift left by one column; new right column = {LB1[col], LB0[col], pixel_in} for rows 0,1,2.
- FSM (2 states): FILL (row < 2, no output); ACTIVE (row >= 2). FILL -> ACTIVE on accepting pixel (1, IMG_WIDTH-1). ACTIVE -> FILL on accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Emit: `window_out_valid` set when accepting a pixel in ACTIVE with col >= 2. Windows never straddle rows (col >= 2 guarantees all three columns come from the current row span).
- `frame_done` set together with the window for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2).

## Timing
- Reset values: `window_out` = 0, `window_out_valid` = 0, `frame_done` = 0, col = row = 0, state FILL, window register 0.
- Latency: `window_out`/`window_out_valid` update on the edge that accepts the completing pixel; visible 1 cycle after that pixel's valid cycle.
- `window_out_valid` and `frame_done` are single-cycle pulses per accepted pixel; back-to-back valid inputs give back-to-back valid outputs.
- Reset asserted mid-frame: all state returns to reset values asynchronously; first pixel after release is treated as (0,0); no partial window from before reset is emitted.

## Configuration
- `SOBEL_WINDOW_FRAME_SYNC_EN` defined: `frame_start` port exists; when `frame_start` = 1 with `pixel_in_valid` = 1, that pixel is taken as (0,0) (counters forced, state FILL), regardless of current position. `frame_start` without `pixel_in_valid` is ignored. If the forced pixel would otherwise have completed a window, no window or `frame_done` is emitted for it.
- Not defined: port absent; counters free-run purely from pixel count.

## Test plan
- W=8, H=6, pixel = 8*row + col streamed continuously -> first `window_out_valid` one cycle after pixel 18; bytes 0..8 = 0,1,2,8,9,10,16,17,18.
- Same frame -> exactly 24 windows; last has byte 8 = 47, byte 0 = 29, with `frame_done` = 1 only on it.
- Same frame with random 0-3 idle cycles between pixels -> identical window sequence; `window_out` stable during gaps.
- Two frames back-to-back, second frame pixel = 100 + index -> second frame's first window bytes 0..8 = 100,101,102,108,109,110,116,117,118; 48 windows total.
- Assert `rstN` = 0 after pixel 30, then restart frame -> outputs 0 during reset, then same 24 windows as first test.
- With `SOBEL_WINDOW_FRAME_SYNC_EN`: pulse `frame_start` on pixel 20 of a frame, then stream a full frame -> no window for that pixel, then 24 correct windows referenced to the new origin.
